// File: rtl/alu_result_wb_pkg.sv
// Shared definitions for the ALU result writeback buffer: default widths,
// the hardwired-zero register index and the FIFO entry layout.
package alu_result_wb_pkg;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int REG_ZERO       = 0;

   // Stored entry layout: destination register in the upper bits, result below.
   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] rd;
      logic [DATA_WIDTH_DEF-1:0] result;
   } wb_entry_t;
endpackage

// File: rtl/alu_result_wb_fifo_mem.sv
// Writeback FIFO storage: one write port, every entry exposed so the
// forwarding compare can scan the whole queue in parallel.
module wb_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [PW-1:0]                waddr,
   input  logic [WIDTH-1:0]             wdata,
   output logic [DEPTH-1:0][WIDTH-1:0]  entries
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;

   // Storage is never reset; readers gate everything by occupancy.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign entries = mem;

endmodule

// File: rtl/alu_result_wb.sv
// In-order writeback buffer between the ALU and the register-file write port,
// with a youngest-first forwarding lookup over in-flight results.
module alu_result_wb
   import alu_result_wb_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_result,
   input  logic [ADDR_WIDTH-1:0]   in_rd,
   output logic                    wb_en,
   output logic [ADDR_WIDTH-1:0]   wb_addr,
   output logic [DATA_WIDTH-1:0]   wb_data,
   input  logic                    wb_ack,
   input  logic [ADDR_WIDTH-1:0]   fwd_addr,
   output logic                    fwd_hit,
   output logic [DATA_WIDTH-1:0]   fwd_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   logic [PW-1:0]               wr_ptr;
   logic [PW-1:0]               rd_ptr;
   logic [CW-1:0]               count_q;
   logic                        full;
   logic                        empty;
   logic                        push;
   logic                        pop;
   logic [DEPTH-1:0][EW-1:0]    entries;
   logic [EW-1:0]               head;
   logic [PW-1:0]               idx;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign wb_en    = !empty;
   assign count    = count_q;

   // r0 results complete the handshake but are never enqueued.
   assign push = in_valid && !full && (in_rd != ADDR_WIDTH'(REG_ZERO));
   assign pop  = !empty && wb_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   wb_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_mem (
      .clk     (clk),
      .we      (push),
      .waddr   (wr_ptr),
      .wdata   ({in_rd, in_result}),
      .entries (entries)
   );

   assign head    = entries[rd_ptr];
   assign wb_addr = empty ? '0 : head[EW-1:DATA_WIDTH];
   assign wb_data = empty ? '0 : head[DATA_WIDTH-1:0];

   // Scan oldest to newest so later matches override, then let the
   // incoming push candidate override everything queued.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if ((CW'(i) < count_q) && (entries[idx][EW-1:DATA_WIDTH] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = entries[idx][DATA_WIDTH-1:0];
         end
      end
      if (in_valid && !full && (in_rd == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = in_result;
      end
      if (fwd_addr == ADDR_WIDTH'(REG_ZERO)) begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
      end
   end

endmodule

// File: doc/alu_result_wb.md
# alu_result_wb

Writeback buffer at the consumer end of the execute stage. It accepts ALU results with their destination register through a valid/ready handshake, queues them in a small in-order FIFO, and drains them one per cycle into the register-file write port under the register file's acknowledge. It also provides a forwarding lookup so the decode/issue logic can read values still in flight before they reach the register file.

## Interface
Parameters:
- DATA_WIDTH, 32, width of result and forwarded data.
- ADDR_WIDTH, 5, register index width.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high. Clears all state immediately.
- in_valid  in  1  ALU result present.
- in_ready  out  1  buffer can accept. Equals !full.
- in_result  in  DATA_WIDTH  ALU result.
- in_rd  in  ADDR_WIDTH  destination register.
- wb_en  out  1  head entry valid. Equals !empty.
- wb_addr  out  ADDR_WIDTH  head destination. Driven 0 when empty.
- wb_data  out  DATA_WIDTH  head result. Driven 0 when empty.
- wb_ack  in  1  register file accepted the head this cycle.
- fwd_addr  in  ADDR_WIDTH  register being looked up.
- fwd_hit  out  1  an in-flight value exists for fwd_addr.
- fwd_data  out  DATA_WIDTH  youngest in-flight value for fwd_addr. 0 when no hit.
- count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Push happens when in_valid && in_ready && in_rd != 0. The entry is written at wr_ptr, then wr_ptr increments.
- Results addressed to r0 are accepted and discarded: handshake completes, nothing is enqueued, and count is unchanged.
- Pop happens when wb_en && wb_ack: rd_ptr increments. wb_ack while empty is ignored.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- Occupancy states: EMPTY (count 0), PARTIAL, FULL (count DEPTH).
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- When FULL, in_ready is 0, so no push is possible. A pop in that cycle moves to PARTIAL, and in_ready rises the following cycle.
- Forwarding (combinational) has priority youngest first:
  1. Current push candidate (in_valid && in_ready && in_rd == fwd_addr).
  2. Queued entries, newest to oldest.
- fwd_addr == 0 always gives fwd_hit = 0 and fwd_data = 0.
- An entry being popped in the current cycle is still visible to forwarding in that cycle.
- Reset mid-operation drops all queued entries. Storage contents need not be cleared because every output is gated by occupancy.

## Timing
- Reset values: in_ready 1, wb_en 0, wb_addr 0, wb_data 0, fwd_hit 0, fwd_data 0, count 0.
- Push-to-writeback latency is 1 cycle. An entry pushed at edge N appears on wb_en/wb_addr/wb_data during cycle N+1.
- Throughput is one push and one pop per cycle sustained.
- in_ready, wb_en and count are functions of registered state only.
- fwd_hit/fwd_data are combinational from registered state, fwd_addr and the in_* inputs. There is no combinational path from wb_ack to any output.

## Structure
- A shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - The constant REG_ZERO = 0.
  - A typedef for a FIFO entry {rd, result}.
- One sub-module, wb_fifo_mem: DEPTH x (ADDR_WIDTH+DATA_WIDTH) register array with one write port and all entries exposed for the forwarding compare.
- Pointer, count and forwarding-priority logic live in alu_result_wb.

## Test plan
- Reset then single push (rd 3, result 0x0000_0010), wb_ack held 1:
  - wb_en=1, wb_addr=3, wb_data=0x10 exactly one cycle later.
  - Next cycle: count back to 0, wb_en=0.
- Fill with wb_ack=0, pushes to rd 1..4 with results 0xA1..0xA4:
  - After 4 pushes: count=4, in_ready=0, and a 5th in_valid is not accepted.
  - One wb_ack: wb_addr=1 popped, in_ready=1 next cycle.
- Push rd 0 with result 0xDEAD:
  - in_ready=1 and the handshake completes.
  - count stays 0, wb_en stays 0, and fwd_addr=0 gives fwd_hit=0.
- Forwarding priority: queue rd 7=0x11 then rd 7=0x22, and present in_rd 7=0x33 with in_valid.
  - fwd_addr=7 gives 0x33 in that cycle.
  - Drop in_valid: gives 0x22.
  - Pop twice: fwd_hit=0.
- Simultaneous push/pop at count 2 for 8 cycles:
  - count stays 2, and pointers wrap past DEPTH.
  - wb_data sequence matches push order exactly.
- Assert reset asynchronously mid-cycle with count 3:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - First push after release appears normally 1 cycle later.
